// File: rtl/serial_crc32_pkg.sv
// Shared CRC-32 constants (reflected IEEE 802.3 polynomial, seed, final XOR, check value).
package serial_crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT        = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_CHECK          = 32'hCBF43926;

endpackage

// File: rtl/crc32_bit_step.sv
// One LSB-first CRC shift step for a reflected polynomial; purely combinational.
module crc32_bit_step
  import serial_crc32_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY_REFLECTED
) (
  input  logic [31:0] crc,
  input  logic        data_bit,
  output logic [31:0] next_crc
);

  logic feedback;

  assign feedback = crc[0] ^ data_bit;
  assign next_crc = (crc >> 1) ^ (feedback ? POLY : 32'h0);

endmodule

// File: rtl/serial_crc32_generator.sv
// Bit-serial CRC-32 generator with registered, finalized output.
// Optional status outputs (crc_valid, bit_count) enabled by macro SERIAL_CRC32_GEN_STATUS_EN.
module serial_crc32_generator
  import serial_crc32_pkg::*;
#(
  parameter logic [31:0] POLY    = CRC32_POLY_REFLECTED,
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] XOR_OUT = CRC32_XOR_OUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        data_in,
  input  logic        new_message,
  output logic [31:0] crc_out
`ifdef SERIAL_CRC32_GEN_STATUS_EN
  ,
  output logic        crc_valid,
  output logic [31:0] bit_count
`endif
);

  logic [31:0] crc_reg;
  logic [31:0] step_base;
  logic [31:0] step_result;
  logic [31:0] crc_next;

  // A restart substitutes INIT as the base, so restart-plus-absorb shares the one step.
  assign step_base = new_message ? INIT : crc_reg;
  assign crc_next  = enable ? step_result : step_base;

  crc32_bit_step #(
    .POLY(POLY)
  ) u_bit_step (
    .crc      (step_base),
    .data_bit (data_in),
    .next_crc (step_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= INIT;
      crc_out <= INIT ^ XOR_OUT;
    end else begin
      crc_reg <= crc_next;
      crc_out <= crc_reg ^ XOR_OUT;
    end
  end

`ifdef SERIAL_CRC32_GEN_STATUS_EN
  // crc_valid rises together with crc_out showing a whole number of bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count <= 32'd0;
      crc_valid <= 1'b0;
    end else begin
      if (new_message) begin
        bit_count <= enable ? 32'd1 : 32'd0;
      end else if (enable) begin
        bit_count <= bit_count + 32'd1;
      end
      crc_valid <= !enable && !new_message &&
                   (bit_count != 32'd0) && (bit_count[2:0] == 3'd0);
    end
  end
`endif

endmodule

// File: tb/tb_serial_crc32_generator.sv
// Self-checking bench for serial_crc32_generator using known CRC-32 vectors.
// Expected results are queued when a message is driven and checked when crc_out settles.
module tb_serial_crc32_generator;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        data_in;
  logic        new_message;
  logic [31:0] crc_out;
`ifdef SERIAL_CRC32_GEN_STATUS_EN
  logic        crc_valid;
  logic [31:0] bit_count;
`endif

  int vectors;
  int miscompares;
  logic [31:0] expect_q[$];

  serial_crc32_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .data_in     (data_in),
    .new_message (new_message),
    .crc_out     (crc_out)
`ifdef SERIAL_CRC32_GEN_STATUS_EN
    ,
    .crc_valid   (crc_valid),
    .bit_count   (bit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge so the rising edge sees them stable.
  task automatic drive_bit(input logic b, input logic nm, input logic en);
    @(negedge clk);
    data_in     = b;
    new_message = nm;
    enable      = en;
  endtask

  task automatic restart();
    drive_bit(1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first_restarts, input int max_gap);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i], first_restarts && (i == 0), 1'b1);
      if (max_gap > 0) begin
        int gap;
        gap = $urandom_range(max_gap, 0);
        for (int g = 0; g < gap; g++) drive_bit(1'($urandom_range(1, 0)), 1'b0, 1'b0);
      end
    end
  endtask

  task automatic send_check_string(input logic first_restarts);
    logic [7:0] msg [9];
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 9; i++) send_byte(msg[i], first_restarts && (i == 0), 0);
  endtask

  // Two idle cycles let crc_out catch up, then the oldest expectation is compared.
  task automatic settle_and_check(input string name);
    logic [31:0] exp_val;
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    vectors++;
    if (expect_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, crc_out=%08h", name, crc_out);
    end else begin
      exp_val = expect_q.pop_front();
      if (crc_out !== exp_val) begin
        miscompares++;
        $display("[TB] FAIL %s: crc_out=%08h expected=%08h", name, crc_out, exp_val);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; data_in = 1'b0; new_message = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (crc_out !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_value: crc_out=%08h expected=00000000", crc_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_check_string();
    restart();
    send_check_string(1'b0);
    expect_q.push_back(32'hCBF43926);
    settle_and_check("check_123456789");
`ifdef SERIAL_CRC32_GEN_STATUS_EN
    vectors++;
    if (bit_count !== 32'd72 || crc_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL status_after_msg: bit_count=%0d crc_valid=%b expected 72/1", bit_count, crc_valid);
    end
    restart();
    drive_bit(1'b0, 1'b0, 1'b0);
    vectors++;
    if (bit_count !== 32'd0 || crc_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL status_after_restart: bit_count=%0d crc_valid=%b expected 0/0", bit_count, crc_valid);
    end
`endif
  endtask

  task automatic test_patterns();
    logic [7:0]  pat  [4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    logic [31:0] crcs [4] = '{32'h2144DF1C, 32'hFFFFFFFF, 32'h6B2DC0BD, 32'hB596E05E};
    for (int p = 0; p < 4; p++) begin
      restart();
      for (int k = 0; k < 4; k++) send_byte(pat[p], 1'b0, 0);
      expect_q.push_back(crcs[p]);
      settle_and_check($sformatf("pattern_%02h", pat[p]));
    end
  endtask

  task automatic test_walking_ones(input int max_gap);
    restart();
    for (int k = 0; k < 8; k++) send_byte(8'(1 << k), 1'b0, max_gap);
    expect_q.push_back(32'hE0631A53);
    settle_and_check(max_gap == 0 ? "walking_ones" : "walking_ones_gaps");
  endtask

  task automatic test_hold();
    restart();
    send_check_string(1'b0);
    expect_q.push_back(32'hCBF43926);
    for (int i = 0; i < 20; i++) drive_bit(1'($urandom_range(1, 0)), 1'b0, 1'b0);
    settle_and_check("hold_idle_20");
  endtask

  task automatic test_back_to_back();
    restart();
    for (int k = 0; k < 4; k++) send_byte(8'hFF, 1'b0, 0);
    send_check_string(1'b1);
    expect_q.push_back(32'hCBF43926);
    settle_and_check("restart_with_first_bit");
  endtask

  task automatic test_reset_mid_message();
    restart();
    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h3C, 1'b0, 0);
    @(negedge clk);
    enable = 1'b1;
    data_in = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (crc_out !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: crc_out=%08h expected=00000000", crc_out);
    end
    @(negedge clk);
    vectors++;
    if (crc_out !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL held_in_reset: crc_out=%08h expected=00000000", crc_out);
    end
    enable = 1'b0;
    rst_n = 1'b1;
    send_check_string(1'b0);
    expect_q.push_back(32'hCBF43926);
    settle_and_check("after_reset_no_restart");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_check_string();
    test_patterns();
    test_walking_ones(0);
    test_walking_ones(3);
    test_hold();
    test_back_to_back();
    test_reset_mid_message();
    if (expect_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries unchecked, expected 0", expect_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_crc32_generator.md
SERIAL_CRC32_GENERATOR -- requirements
Module: serial_crc32_generator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter POLY, default 32'hEDB88320, SHALL be the reflected CRC polynomial.
REQ-003 Parameter INIT, default 32'hFFFFFFFF, SHALL be the seed loaded at reset and on new_message.
REQ-004 Parameter XOR_OUT, default 32'hFFFFFFFF, SHALL be the final XOR applied to the output.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port enable, input, 1 bit: when high, data_in is absorbed this cycle.
REQ-008 Port data_in, input, 1 bit: serial message bit, LSB of each byte first.
REQ-009 Port new_message, input, 1 bit: when high, the running CRC restarts from INIT.
REQ-010 Port crc_out, output, 32 bits: registered, finalized CRC of all bits absorbed since the last restart.

Function
REQ-011 Internal state crc_reg (32 bits) SHALL update once per rising edge, only when enable or new_message is high; otherwise it SHALL hold.
REQ-012 Bit step SHALL be: fb = crc_reg[0] ^ data_in; next = (crc_reg >> 1) ^ (fb ? POLY : 0).
REQ-013 With new_message=1 and enable=0, crc_reg SHALL load INIT.
REQ-014 With new_message=1 and enable=1, the bit step SHALL be applied to INIT (restart plus absorb data_in in the same cycle).
REQ-015 crc_out SHALL be a register loaded each rising edge with crc_reg ^ XOR_OUT; crc_out therefore reflects a bit one cycle after crc_reg absorbs it (two edges after data is presented).
REQ-016 No bit reflection SHALL be applied to crc_out; with default parameters the result SHALL equal standard CRC-32 (IEEE 802.3/zlib).
REQ-017 enable low for any number of cycles SHALL NOT alter crc_reg or the final value of crc_out.
REQ-018 Message length SHALL be unbounded; no internal counter SHALL limit it.

Reset
REQ-019 On rst_n low, crc_reg SHALL become INIT and crc_out SHALL become INIT ^ XOR_OUT (32'h00000000 with defaults), asynchronously.
REQ-020 Reset asserted mid-message SHALL discard all absorbed bits; after release, absorption SHALL continue from INIT without requiring new_message.

Configuration
REQ-021 Macro SERIAL_CRC32_GEN_STATUS_EN SHALL, when defined, add outputs crc_valid (1 bit) and bit_count (32 bits); when undefined, these ports and their logic SHALL NOT exist and all other behaviour SHALL be identical.
REQ-022 bit_count SHALL reset to 0, load 0 on new_message alone, load 1 on new_message with enable, increment on each enable-only cycle, and wrap at 2^32.
REQ-023 crc_valid SHALL be registered, reset to 0, and go high the cycle crc_out first reflects a completed byte (bit_count multiple of 8 and nonzero) with enable low; it SHALL clear on any enable or new_message cycle.

Structure
REQ-024 A shared package serial_crc32_pkg SHALL hold CRC32_POLY_REFLECTED, CRC32_INIT, CRC32_XOR_OUT and the check value CRC32_CHECK = 32'hCBF43926.
REQ-025 A combinational sub-module crc32_bit_step SHALL implement REQ-012 (inputs crc, bit; output next crc), parameterized by POLY.

Verification
REQ-026 Restart, then ASCII "123456789" (31..39) LSB-first, then two idle cycles -> crc_out = 32'hCBF43926.
REQ-027 Restart, then 4 bytes 00 -> 32'h2144DF1C; 4 bytes FF -> 32'hFFFFFFFF.
REQ-028 Restart, then 4 bytes 55 -> 32'h6B2DC0BD; 4 bytes AA -> 32'hB596E05E.
REQ-029 Restart, then bytes 01,02,04,08,10,20,40,80 -> 32'hE0631A53; repeat with enable deasserted randomly between bits -> same value.
REQ-030 Reset pulse during a message, then "123456789" without new_message -> 32'hCBF43926; crc_out = 0 while in reset.
REQ-031 With SERIAL_CRC32_GEN_STATUS_EN defined: after "123456789", bit_count = 72 and crc_valid = 1; new_message clears both.
